// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin sharing of one 4-bit HD44780 write bus between two byte requesters.
// Define LCD_AUTOINIT_EN to make the block run the LCD power-up init sequence itself.
module lcd_bus_arbiter #(
    parameter int E_CYC     = 2,
    parameter int CMD_CYC   = 4,
    parameter int LONG_CYC  = 16,
    parameter int PWRUP_CYC = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       A_VALID,
    input  logic       A_RS,
    input  logic [7:0] A_DATA,
    output logic       A_READY,
    input  logic       B_VALID,
    input  logic       B_RS,
    input  logic [7:0] B_DATA,
    output logic       B_READY,
    output logic       BUSY,
    output logic       INIT_DONE,
    output logic       RS,
    output logic       E,
    output logic       D4,
    output logic       D5,
    output logic       D6,
    output logic       D7,
    output logic [2:0] dbg_state
);
`ifdef LCD_AUTOINIT_EN
    localparam bit AUTOINIT = 1'b1;
`else
    localparam bit AUTOINIT = 1'b0;
`endif
    localparam int CW = 16;

    typedef enum logic [2:0] {
        PWRUP, INIT_NIB, INIT_BYTE, IDLE, NIB_SETUP, NIB_EHI, NIB_HOLD, SETTLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, settle_last;
    logic [7:0]    data_q, data_n, ib;
    logic [3:0]    nib, nib_n;
    logic [1:0]    idx, idx_n;
    logic          cap_rs, cap_rs_n, hi_q, hi_n, single_q, single_n, long_q, long_n;
    logic          init_mode, init_mode_n, last_grant, last_n, rs_n;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // last_grant: 0 = A, 1 = B; the requester not granted last wins a tie
    assign A_READY = (state == IDLE) && INIT_DONE && A_VALID && (!B_VALID || last_grant);
    assign B_READY = (state == IDLE) && INIT_DONE && B_VALID && (!A_VALID || !last_grant);
    assign {D7, D6, D5, D4} = nib;
    assign dbg_state   = state;
    assign ib          = init_byte(idx);
    assign settle_last = long_q ? CW'(LONG_CYC - 1) : CW'(CMD_CYC - 1);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CW'(1);
        data_n      = data_q;
        cap_rs_n    = cap_rs;
        hi_n        = hi_q;
        single_n    = single_q;
        long_n      = long_q;
        init_mode_n = init_mode;
        idx_n       = idx;
        last_n      = last_grant;
        rs_n        = RS;
        nib_n       = nib;
        case (state)
            PWRUP: begin
                if (cnt == CW'(PWRUP_CYC - 1)) begin
                    state_n     = INIT_NIB;
                    cnt_n       = '0;
                    idx_n       = '0;
                    init_mode_n = 1'b1;
                end
            end
            INIT_NIB: begin
                state_n  = NIB_SETUP;
                cnt_n    = '0;
                cap_rs_n = 1'b0;
                single_n = 1'b1;
                hi_n     = 1'b1;
                rs_n     = 1'b0;
                nib_n    = (idx == 2'd3) ? 4'h2 : 4'h3;
                data_n   = {nib_n, 4'h0};
            end
            INIT_BYTE: begin
                state_n  = NIB_SETUP;
                cnt_n    = '0;
                cap_rs_n = 1'b0;
                single_n = 1'b0;
                hi_n     = 1'b1;
                rs_n     = 1'b0;
                data_n   = ib;
                nib_n    = ib[7:4];
            end
            IDLE: begin
                cnt_n = '0;
                if (A_READY || B_READY) begin
                    state_n  = NIB_SETUP;
                    single_n = 1'b0;
                    hi_n     = 1'b1;
                    last_n   = B_READY;
                    cap_rs_n = A_READY ? A_RS : B_RS;
                    data_n   = A_READY ? A_DATA : B_DATA;
                    rs_n     = cap_rs_n;
                    nib_n    = data_n[7:4];
                end
            end
            NIB_SETUP: begin
                state_n = NIB_EHI;
                cnt_n   = '0;
            end
            NIB_EHI: begin
                if (cnt == CW'(E_CYC - 1)) begin
                    state_n = NIB_HOLD;
                    cnt_n   = '0;
                end
            end
            NIB_HOLD: begin
                cnt_n = '0;
                if (hi_q && !single_q) begin
                    state_n = NIB_SETUP;
                    hi_n    = 1'b0;
                    nib_n   = data_q[3:0];
                end else begin
                    // clear/home (0x01-0x03) and init nibbles need the long settle
                    state_n = SETTLE;
                    long_n  = single_q || (!cap_rs && (data_q[7:2] == 6'd0));
                end
            end
            SETTLE: begin
                if (cnt == settle_last) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (init_mode) begin
                        if (single_q) begin
                            state_n = (idx == 2'd3) ? INIT_BYTE : INIT_NIB;
                            idx_n   = idx + 2'd1;
                        end else if (idx != 2'd3) begin
                            state_n = INIT_BYTE;
                            idx_n   = idx + 2'd1;
                        end else begin
                            init_mode_n = 1'b0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (AUTOINIT) state <= PWRUP;
            else          state <= IDLE;
            cnt        <= '0;
            data_q     <= '0;
            cap_rs     <= 1'b0;
            hi_q       <= 1'b0;
            single_q   <= 1'b0;
            long_q     <= 1'b0;
            init_mode  <= 1'b0;
            idx        <= '0;
            last_grant <= 1'b1;
            RS         <= 1'b0;
            nib        <= '0;
            E          <= 1'b0;
            BUSY       <= 1'b1;
            INIT_DONE  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            data_q     <= data_n;
            cap_rs     <= cap_rs_n;
            hi_q       <= hi_n;
            single_q   <= single_n;
            long_q     <= long_n;
            init_mode  <= init_mode_n;
            idx        <= idx_n;
            last_grant <= last_n;
            RS         <= rs_n;
            nib        <= nib_n;
            E          <= (state_n == NIB_EHI);
            BUSY       <= (state_n != IDLE);
            INIT_DONE  <= INIT_DONE | (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: reset, timing, settle lengths, round robin, capture, abort.
module tb_lcd_bus_arbiter;
  localparam int E_CYC = 2;

  logic       CLK = 1'b0, RST = 1'b0;
  logic       A_VALID = 1'b0, A_RS = 1'b0, B_VALID = 1'b0, B_RS = 1'b0;
  logic [7:0] A_DATA = 8'h00, B_DATA = 8'h00;
  logic       A_READY, B_READY, BUSY, INIT_DONE, RS, E, D4, D5, D6, D7;
  logic [2:0] dbg_state;

  lcd_bus_arbiter dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_RS(A_RS), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_RS(B_RS), .B_DATA(B_DATA), .B_READY(B_READY),
    .BUSY(BUSY), .INIT_DONE(INIT_DONE), .RS(RS), .E(E),
    .D4(D4), .D5(D5), .D6(D6), .D7(D7), .dbg_state(dbg_state)
  );

  // clock
  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [4:0] exp_q[$];
  logic       e_prev = 1'b0;
  int         e_width = 0;
  bit         skip_width = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
  endtask

  // scoreboard: each E rise must carry the next expected {RS, D7..D4}
  always @(negedge CLK) begin
    logic [4:0] v;
    if (E && !e_prev) begin
      if (exp_q.size() == 0) check("bus_unexpected_strobe", 32'(1), 32'(0));
      else begin
        v = exp_q.pop_front();
        check("bus_nibble", 32'({RS, D7, D6, D5, D4}), 32'(v));
      end
    end
    if (E) e_width++;
    if (!E && e_prev) begin
      if (skip_width) skip_width = 1'b0;
      else check("e_width", 32'(e_width), 32'(E_CYC));
      e_width = 0;
    end
    e_prev = E;
  end

  // call at the posedge of cycle T+1 (+#1); returns at the negedge of the idle cycle
  task automatic measure(input string tag, input int exp_idle);
    int   r1 = -1;
    int   r2 = -1;
    int   idl = -1;
    logic ep = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (k == 1) check({tag, "_busy"}, 32'(BUSY), 32'(1));
      if (E && !ep) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      ep = E;
      if (!BUSY) begin
        idl = k;
        break;
      end
    end
    check({tag, "_e_rise1"}, 32'(r1), 32'(2));
    check({tag, "_e_rise2"}, 32'(r2), 32'(E_CYC + 4));
    check({tag, "_idle_at"}, 32'(idl), 32'(exp_idle));
  endtask

  // releases reset at a negedge and waits until the bus is open to requesters
  task automatic release_check();
    int k;
    RST = 1'b1;
`ifdef LCD_AUTOINIT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h06);
    k = 0;
    while (k < 100) begin
      @(posedge CLK); #1;
      k++;
      if (E) break;
    end
    check("init_first_e_rise", 32'(k), 32'(34));
    k = 0;
    while (!INIT_DONE && k < 3000) begin
      @(posedge CLK); #1;
      k++;
    end
    check("init_done", 32'(INIT_DONE), 32'(1));
    check("init_busy_low", 32'(BUSY), 32'(0));
    check("init_seq_consumed", 32'(exp_q.size()), 32'(0));
`else
    k = 0;
    @(posedge CLK); #1;
    check("init_done_after_release", 32'(INIT_DONE), 32'(1));
    check("busy_low_after_release", 32'(BUSY), 32'(0));
`endif
    @(negedge CLK);
  endtask

  logic [7:0] a_tab[3];
  logic [7:0] b_tab[3];
  logic [7:0] cmd_tab[4];
  int         cmd_idle[4];

  initial begin
    int ai;
    int bi;
    a_tab    = '{8'h31, 8'h53, 8'h75};
    b_tab    = '{8'h42, 8'h64, 8'h86};
    cmd_tab  = '{8'h01, 8'h03, 8'h04, 8'h80};
    cmd_idle = '{25, 25, 13, 13};

    // reset
    A_VALID = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_e", 32'(E), 32'(0));
    check("rst_rs", 32'(RS), 32'(0));
    check("rst_d", 32'({D7, D6, D5, D4}), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(1));
    check("rst_init_done", 32'(INIT_DONE), 32'(0));
    check("rst_a_ready", 32'(A_READY), 32'(0));
    A_VALID = 1'b0;
    release_check();

    // both requesters held valid: A, B, A, B
    ai = 0;
    bi = 0;
    A_RS = 1'b1; B_RS = 1'b1;
    A_DATA = a_tab[0]; B_DATA = b_tab[0];
    A_VALID = 1'b1; B_VALID = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_a_ready", 32'(A_READY), 32'(i % 2 == 0));
      check("rr_b_ready", 32'(B_READY), 32'(i % 2 == 1));
      if (i % 2 == 0) push_byte(1'b1, a_tab[ai]);
      else push_byte(1'b1, b_tab[bi]);
      @(posedge CLK); #1;
      if (i % 2 == 0) begin ai++; A_DATA = a_tab[ai]; end
      else begin bi++; B_DATA = b_tab[bi]; end
      if (i == 3) begin A_VALID = 1'b0; B_VALID = 1'b0; end
      measure("rr", 13);
    end

    // single data byte from A
    A_RS = 1'b1; A_DATA = 8'h48; A_VALID = 1'b1;
    #1;
    check("a48_a_ready", 32'(A_READY), 32'(1));
    check("a48_b_ready", 32'(B_READY), 32'(0));
    push_byte(1'b1, 8'h48);
    @(posedge CLK); #1;
    check("a48_ready_one_cycle", 32'(A_READY), 32'(0));
    A_VALID = 1'b0;
    measure("a48", 13);
    check("idle_rs_held", 32'(RS), 32'(1));
    check("idle_d_held", 32'({D7, D6, D5, D4}), 32'(4'h8));

    // commands from B: clear/home boundary vs normal settle
    for (int i = 0; i < 4; i++) begin
      B_RS = 1'b0; B_DATA = cmd_tab[i]; B_VALID = 1'b1;
      #1;
      check("cmd_b_ready", 32'(B_READY), 32'(1));
      push_byte(1'b0, cmd_tab[i]);
      @(posedge CLK); #1;
      B_VALID = 1'b0;
      measure("cmd", cmd_idle[i]);
    end

    // A's inputs change after capture; B arrives mid-transfer
    A_RS = 1'b1; A_DATA = 8'h5A; A_VALID = 1'b1;
    #1;
    check("cap_a_ready", 32'(A_READY), 32'(1));
    push_byte(1'b1, 8'h5A);
    @(posedge CLK); #1;
    A_VALID = 1'b0; A_RS = 1'b0; A_DATA = 8'hFF;
    B_RS = 1'b1; B_DATA = 8'h3C; B_VALID = 1'b1;
    measure("cap", 13);
    #1;
    check("cap_b_granted", 32'(B_READY), 32'(1));
    check("cap_a_not_granted", 32'(A_READY), 32'(0));
    push_byte(1'b1, 8'h3C);
    @(posedge CLK); #1;
    B_VALID = 1'b0;
    measure("late_b", 13);

    // reset while E is high
    A_RS = 1'b1; A_DATA = 8'h77; A_VALID = 1'b1;
    #1;
    check("abort_a_ready", 32'(A_READY), 32'(1));
    exp_q.push_back({1'b1, 4'h7});
    @(posedge CLK); #1;
    A_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_e_high", 32'(E), 32'(1));
    skip_width = 1'b1;
    RST = 1'b0;
    @(posedge CLK); #1;
    check("abort_e", 32'(E), 32'(0));
    check("abort_rs", 32'(RS), 32'(0));
    check("abort_d", 32'({D7, D6, D5, D4}), 32'(0));
    check("abort_busy", 32'(BUSY), 32'(1));
    check("abort_init_done", 32'(INIT_DONE), 32'(0));
    @(negedge CLK);
    release_check();

    repeat (5) @(negedge CLK);
    check("no_pending_nibbles", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
